// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic scaled-adder slice:
//   - clogb2       : bits needed to index/count 'value' distinct states
//   - SC_SEL_RR    : select mode, internal round-robin index
//   - SC_SEL_EXT   : select mode, index taken from sel_ext
//   - sc_state_e   : window FSM states (IDLE, RUN)
// -----------------------------------------------------------------------------
package sc_pkg;

  localparam int SC_SEL_RR  = 0;
  localparam int SC_SEL_EXT = 1;

  typedef enum logic {
    SC_IDLE = 1'b0,
    SC_RUN  = 1'b1
  } sc_state_e;

  // ceil(log2(value)), never less than 1 so degenerate sizes stay legal.
  function automatic int clogb2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sc_stream_counter.sv
// -----------------------------------------------------------------------------
// sc_stream_counter
// Windowed bit/ones counter for a stochastic stream. Counts accepted bits and
// the ones among them; on the WINDOW-th bit it latches the final ones count
// and pulses o_done one cycle later. A clear coincident with an enable makes
// that bit the first of a fresh window.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : discard the running window
//   i_en       : a bit belonging to the window is accepted this cycle
//   i_bit      : value of that bit
//   o_last     : combinational, this accepted bit completes the window
//   o_done     : registered one-cycle pulse, o_count updated
//   o_count    : ones over the last completed window (held)
// -----------------------------------------------------------------------------
module sc_stream_counter #(
  parameter int WINDOW      = 256,
  parameter int COUNT_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_en,
  input  logic                   i_bit,
  output logic                   o_last,
  output logic                   o_done,
  output logic [COUNT_WIDTH-1:0] o_count
);

  logic [COUNT_WIDTH-1:0] r_bits;
  logic [COUNT_WIDTH-1:0] r_ones;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_done;
  logic [COUNT_WIDTH-1:0] w_bits_nxt;
  logic [COUNT_WIDTH-1:0] w_ones_nxt;

  // A clear folds into the same cycle's update so a start+bit is counted.
  always_comb begin
    w_bits_nxt = (i_clear ? '0 : r_bits) + COUNT_WIDTH'(1);
    w_ones_nxt = (i_clear ? '0 : r_ones) + COUNT_WIDTH'(i_bit);
    o_last     = i_en && (w_bits_nxt == COUNT_WIDTH'(WINDOW));
  end

  // Stage p0 -> p1: window accumulation and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits  <= '0;
      r_ones  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= o_last;
      if (o_last) begin
        r_bits  <= '0;
        r_ones  <= '0;
        r_count <= w_ones_nxt;
      end else if (i_en) begin
        r_bits <= w_bits_nxt;
        r_ones <= w_ones_nxt;
      end else if (i_clear) begin
        r_bits <= '0;
        r_ones <= '0;
      end
    end
  end

  assign o_done  = r_done;
  assign o_count = r_count;

endmodule

// File: rtl/sc_nadder_acc.sv
// -----------------------------------------------------------------------------
// sc_nadder_acc
// Stochastic scaled adder: out = (1/N)*sum(x_i), realised by muxing one input
// stream per accepted cycle, with optional windowed count of the output ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : x / sel_ext valid this cycle (always accepted)
//   x          : one bit of each of the INPUT_STREAMS streams
//   sel_ext    : external stream index (SEL_MODE = SC_SEL_EXT only)
//   start      : begin or restart a conversion window
//   out_bit    : registered scaled-sum stream bit
//   out_valid  : out_bit valid (in_valid delayed one cycle)
//   sum_count  : ones in out_bit over the last completed window
//   sum_valid  : one-cycle pulse when sum_count updates
//   busy       : window in progress
//   sel_err    : sticky, an out-of-range sel_ext was accepted
// -----------------------------------------------------------------------------
module sc_nadder_acc
  import sc_pkg::*;
#(
  parameter int INPUT_STREAMS = 4,
  parameter int SEL_MODE      = SC_SEL_RR,
  parameter int WINDOW        = 256,
  parameter int CONTINUOUS    = 0,
  parameter int SELECT_WIDTH  = clogb2(INPUT_STREAMS),
  parameter int COUNT_WIDTH   = clogb2(WINDOW + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [INPUT_STREAMS-1:0] x,
  input  logic [SELECT_WIDTH-1:0]  sel_ext,
  input  logic                     start,
  output logic                     out_bit,
  output logic                     out_valid,
  output logic [COUNT_WIDTH-1:0]   sum_count,
  output logic                     sum_valid,
  output logic                     busy,
  output logic                     sel_err
);

  sc_state_e               r_state;
  logic [SELECT_WIDTH-1:0] r_idx;
  logic                    r_out_bit_p1;
  logic                    r_out_vld_p1;
  logic                    r_sel_err;

  logic [SELECT_WIDTH-1:0] w_rr_idx;
  logic [SELECT_WIDTH-1:0] w_rr_nxt;
  logic [SELECT_WIDTH-1:0] w_idx;
  logic                    w_in_range;
  logic                    w_bit;
  logic                    w_count_en;
  logic                    w_last;
  logic                    w_unused_sel;

  // In round-robin mode sel_ext carries no information.
  assign w_unused_sel = ^sel_ext;

  // A start restarts round-robin at stream 0 for the bit accepted with it.
  always_comb begin
    w_rr_idx   = start ? '0 : r_idx;
    w_rr_nxt   = (w_rr_idx == SELECT_WIDTH'(INPUT_STREAMS - 1)) ? '0
                 : w_rr_idx + SELECT_WIDTH'(1);
    w_idx      = (SEL_MODE == SC_SEL_EXT) ? sel_ext : w_rr_idx;
    // Extra bit so the compare is valid when N is a power of two.
    w_in_range = ({1'b0, w_idx} < (SELECT_WIDTH + 1)'(INPUT_STREAMS));
    w_bit      = w_in_range ? x[w_idx] : 1'b0;
    w_count_en = in_valid && (start || (r_state == SC_RUN));
  end

  // Stage p0 -> p1: select advance, mux register, error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_out_bit_p1 <= 1'b0;
      r_out_vld_p1 <= 1'b0;
      r_sel_err    <= 1'b0;
    end else begin
      r_out_vld_p1 <= in_valid;
      if (in_valid) begin
        r_idx        <= w_rr_nxt;
        r_out_bit_p1 <= w_bit;
      end else if (start) begin
        r_idx <= '0;
      end
      if (in_valid && (SEL_MODE == SC_SEL_EXT) && !w_in_range)
        r_sel_err <= 1'b1;
    end
  end

  // Completion wins over start so a one-bit window opened by start still ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SC_IDLE;
    end else if (w_last && (CONTINUOUS == 0)) begin
      r_state <= SC_IDLE;
    end else if (start) begin
      r_state <= SC_RUN;
    end
  end

  sc_stream_counter #(
    .WINDOW      (WINDOW),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (start),
    .i_en    (w_count_en),
    .i_bit   (w_bit),
    .o_last  (w_last),
    .o_done  (sum_valid),
    .o_count (sum_count)
  );

  assign out_bit   = r_out_bit_p1;
  assign out_valid = r_out_vld_p1;
  assign busy      = (r_state == SC_RUN);
  assign sel_err   = r_sel_err;

endmodule
